// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for the MIPS-subset datapath.
// Steps each instruction through IF/ID/EX/MEM/WB and handshakes with a variable-latency data memory.
module mc_ctrl #(
  parameter logic [3:0] MEM_TIMEOUT = 4'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  input  logic        Zero,
  input  logic        mem_ack,
  output logic        PCWr,
  output logic [1:0]  PCSrc,
  output logic        IRWr,
  output logic        ExtOp,
  output logic        ALUSrc,
  output logic [2:0]  ALUctr,
  output logic        RegDst,
  output logic        RegWr,
  output logic        MemtoReg,
  output logic        MemRead,
  output logic        MemWr,
  output logic [2:0]  state,
  output logic        halted,
  output logic [1:0]  err,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_ORI, C_ADDIU, C_LW, C_SW, C_BEQ, C_J
  } cls_t;

  state_t     cur;
  cls_t       cls_q;
  logic [2:0] alu_q;
  logic [3:0] wait_cnt;

  logic       dec_ok;
  cls_t       dec_cls;
  logic [2:0] dec_alu;

  assign state = cur;

  always_comb begin
    dec_ok  = 1'b1;
    dec_cls = C_R;
    dec_alu = 3'b000;
    case (op)
      6'b000000: begin
        case (func)
          6'b100001: dec_alu = 3'b000;
          6'b100011: dec_alu = 3'b100;
          6'b100101: dec_alu = 3'b010;
          6'b101010: dec_alu = 3'b111;
          default:   dec_ok  = 1'b0;
        endcase
      end
      6'b001101: begin dec_cls = C_ORI;   dec_alu = 3'b010; end
      6'b001001: dec_cls = C_ADDIU;
      6'b100011: dec_cls = C_LW;
      6'b101011: dec_cls = C_SW;
      6'b000100: begin dec_cls = C_BEQ;   dec_alu = 3'b100; end
      6'b000010: dec_cls = C_J;
      default:   dec_ok = 1'b0;
    endcase
  end

  // The timeout fires on the cycle wait_cnt would reach MEM_TIMEOUT; an ack in that same cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= S_IF;
      cls_q    <= C_R;
      alu_q    <= 3'b000;
      wait_cnt <= 4'd0;
      halted   <= 1'b0;
      err      <= 2'b00;
      retired  <= 32'd0;
    end else begin
      case (cur)
        S_IF: cur <= S_ID;
        S_ID: begin
          if (!dec_ok) begin
            err    <= 2'b01;
            halted <= 1'b1;
            cur    <= S_HALT;
          end else begin
            cls_q <= dec_cls;
            alu_q <= dec_alu;
            if (dec_cls == C_J) begin
              retired <= retired + 32'd1;
              cur     <= S_IF;
            end else begin
              cur <= S_EX;
            end
          end
        end
        S_EX: begin
          wait_cnt <= 4'd0;
          case (cls_q)
            C_BEQ: begin
              retired <= retired + 32'd1;
              cur     <= S_IF;
            end
            C_LW, C_SW: cur <= S_MEM;
            default:    cur <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            if (cls_q == C_LW) begin
              cur <= S_WB;
            end else begin
              retired <= retired + 32'd1;
              cur     <= S_IF;
            end
          end else if (wait_cnt == MEM_TIMEOUT - 4'd1) begin
            err    <= 2'b10;
            halted <= 1'b1;
            cur    <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_WB: begin
          retired <= retired + 32'd1;
          cur     <= S_IF;
        end
        S_HALT: cur <= S_HALT;
        default: cur <= S_IF;
      endcase
    end
  end

  // Moore decode from state and latched class; only ID (jump) looks at op, and BEQ's PCWr follows Zero.
  always_comb begin
    PCWr     = 1'b0;
    PCSrc    = 2'b00;
    IRWr     = 1'b0;
    ExtOp    = 1'b0;
    ALUSrc   = 1'b0;
    ALUctr   = 3'b000;
    RegDst   = 1'b0;
    RegWr    = 1'b0;
    MemtoReg = 1'b0;
    MemRead  = 1'b0;
    MemWr    = 1'b0;
    case (cur)
      S_IF: begin
        IRWr = 1'b1;
        PCWr = 1'b1;
      end
      S_ID: begin
        if (dec_ok && dec_cls == C_J) begin
          PCWr  = 1'b1;
          PCSrc = 2'b10;
        end
      end
      S_EX: begin
        ALUctr = alu_q;
        ALUSrc = (cls_q == C_ORI) || (cls_q == C_ADDIU) || (cls_q == C_LW) || (cls_q == C_SW);
        ExtOp  = (cls_q == C_ADDIU) || (cls_q == C_LW) || (cls_q == C_SW);
        if (cls_q == C_BEQ) begin
          PCWr  = Zero;
          PCSrc = 2'b01;
        end
      end
      S_MEM: begin
        MemRead = (cls_q == C_LW);
        MemWr   = (cls_q == C_SW);
      end
      S_WB: begin
        RegWr    = 1'b1;
        RegDst   = (cls_q == C_R);
        MemtoReg = (cls_q == C_LW);
      end
      default: ;
    endcase
    if (rst) begin
      PCWr    = 1'b0;
      IRWr    = 1'b0;
      RegWr   = 1'b0;
      MemRead = 1'b0;
      MemWr   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized scoreboard bench for mc_ctrl: an instruction-level model queues the expected
// per-cycle controls, and a negedge monitor pops and compares them.
module tb_mc_ctrl;

  localparam logic [3:0] MEM_TIMEOUT = 4'd15;

  localparam int P_IF = 0, P_ID = 1, P_EX = 2, P_MEM = 3, P_WB = 4, P_HALT = 7;
  localparam int K_R = 0, K_ORI = 1, K_ADDIU = 2, K_LW = 3, K_SW = 4, K_BEQ = 5, K_J = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  op = '0;
  logic [5:0]  func = '0;
  logic        Zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic        PCWr, IRWr, ExtOp, ALUSrc, RegDst, RegWr, MemtoReg, MemRead, MemWr, halted;
  logic [1:0]  PCSrc, err;
  logic [2:0]  ALUctr, state;
  logic [31:0] retired;

  always #5 clk = ~clk;

  mc_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .Zero(Zero), .mem_ack(mem_ack),
    .PCWr(PCWr), .PCSrc(PCSrc), .IRWr(IRWr), .ExtOp(ExtOp), .ALUSrc(ALUSrc),
    .ALUctr(ALUctr), .RegDst(RegDst), .RegWr(RegWr), .MemtoReg(MemtoReg),
    .MemRead(MemRead), .MemWr(MemWr), .state(state), .halted(halted), .err(err),
    .retired(retired)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        pcwr;
    logic [1:0]  pcsrc;
    logic        irwr;
    logic        extop;
    logic        alusrc;
    logic [2:0]  aluctr;
    logic        regdst;
    logic        regwr;
    logic        memtoreg;
    logic        memread;
    logic        memwr;
    logic        halted;
    logic [1:0]  err;
    logic [31:0] retired;
  } ctl_t;

  typedef struct {
    ctl_t  c;
    bit    enOnly;
    string tag;
  } exp_t;

  exp_t expQ[$];
  int nCompared = 0;
  int nMismatched = 0;

  // Architectural status as the instruction-level model sees it
  logic [31:0] mRetired = '0;
  logic [1:0]  mErr = '0;
  logic        mHalted = 1'b0;

  // Instruction table: legality, class and ALU operation
  function automatic void lookupInstr(input logic [5:0] o, input logic [5:0] f,
                                      output bit legal, output int kind, output logic [2:0] aluc);
    legal = 1'b1;
    kind  = K_R;
    aluc  = 3'b000;
    if (o == 6'h00) begin
      if      (f == 6'h21) aluc = 3'b000;
      else if (f == 6'h23) aluc = 3'b100;
      else if (f == 6'h25) aluc = 3'b010;
      else if (f == 6'h2a) aluc = 3'b111;
      else legal = 1'b0;
    end
    else if (o == 6'h0d) begin kind = K_ORI;   aluc = 3'b010; end
    else if (o == 6'h09) kind = K_ADDIU;
    else if (o == 6'h23) kind = K_LW;
    else if (o == 6'h2b) kind = K_SW;
    else if (o == 6'h04) begin kind = K_BEQ;   aluc = 3'b100; end
    else if (o == 6'h02) kind = K_J;
    else legal = 1'b0;
  endfunction

  task automatic applyStimulus(input bit r, input bit z, input bit a, input logic [5:0] o,
                               input logic [5:0] f, input ctl_t c, input bit enOnly, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; Zero = z; mem_ack = a; op = o; func = f;
    e.c = c; e.enOnly = enOnly; e.tag = tag;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    ctl_t got;
    got = '{state, PCWr, PCSrc, IRWr, ExtOp, ALUSrc, ALUctr, RegDst, RegWr, MemtoReg,
            MemRead, MemWr, halted, err, retired};
    nCompared++;
    if (e.enOnly) begin
      if ({PCWr, IRWr, RegWr, MemRead, MemWr} != 5'b0) begin
        nMismatched++;
        $display("[TB] FAIL %s enables under rst: got %b want 00000", e.tag,
                 {PCWr, IRWr, RegWr, MemRead, MemWr});
      end
    end else if (got != e.c) begin
      nMismatched++;
      $display("[TB] FAIL %s state%0d: got %h want %h (retired got %0d want %0d)",
               e.tag, e.c.st, got, e.c, got.retired, e.c.retired);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  task automatic doReset(input int n);
    ctl_t c;
    c = '0;
    repeat (n) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), c, 1'b1, "reset");
    mRetired = '0; mErr = '0; mHalted = 1'b0;
  endtask

  task automatic runHalt(input int n);
    ctl_t c;
    c = '0;
    c.st = 3'(P_HALT); c.halted = 1'b1; c.err = mErr; c.retired = mRetired;
    repeat (n) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                             6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), c, 1'b0, "halt");
  endtask

  // ack = MEM cycle (1-based) on which mem_ack rises, 0 = never; abortAt = cycle index pulsing rst, -1 = none
  task automatic runInstr(input logic [5:0] o, input logic [5:0] f, input bit z, input int ack,
                          input int abortAt, input string tag);
    bit legal; int kind; logic [2:0] aluc;
    int phases[$];
    int memIdx, nMem;
    bit isMem, zz, a;
    ctl_t c;
    lookupInstr(o, f, legal, kind, aluc);
    isMem = (kind == K_LW) || (kind == K_SW);
    phases.push_back(P_IF);
    phases.push_back(P_ID);
    if (legal && kind != K_J) begin
      phases.push_back(P_EX);
      if (isMem) begin
        nMem = (ack > 0) ? ack : int'(MEM_TIMEOUT);
        repeat (nMem) phases.push_back(P_MEM);
      end
      if (kind == K_R || kind == K_ORI || kind == K_ADDIU || (kind == K_LW && ack > 0))
        phases.push_back(P_WB);
    end
    memIdx = 0;
    foreach (phases[i]) begin
      c = '0;
      c.st = 3'(phases[i]); c.retired = mRetired; c.err = mErr; c.halted = mHalted;
      zz = 1'($urandom_range(0, 1));
      a  = 1'($urandom_range(0, 1));
      case (phases[i])
        P_IF: begin c.irwr = 1'b1; c.pcwr = 1'b1; end
        P_ID: if (legal && kind == K_J) begin c.pcwr = 1'b1; c.pcsrc = 2'b10; end
        P_EX: begin
          c.aluctr = aluc;
          c.alusrc = (kind != K_R) && (kind != K_BEQ);
          c.extop  = (kind == K_ADDIU) || isMem;
          zz = z;
          if (kind == K_BEQ) begin c.pcwr = z; c.pcsrc = 2'b01; end
        end
        P_MEM: begin
          a = (ack > 0) && (memIdx == ack - 1);
          memIdx++;
          c.memread = (kind == K_LW);
          c.memwr   = (kind == K_SW);
        end
        P_WB: begin
          c.regwr    = 1'b1;
          c.regdst   = (kind == K_R);
          c.memtoreg = (kind == K_LW);
        end
        default: ;
      endcase
      if (i == abortAt) begin
        applyStimulus(1'b1, zz, a, o, f, c, 1'b1, {tag, "-abort"});
        mRetired = '0; mErr = '0; mHalted = 1'b0;
        return;
      end
      applyStimulus(1'b0, zz, a, o, f, c, 1'b0, tag);
    end
    if (!legal) begin
      mErr = 2'b01; mHalted = 1'b1;
    end else if (isMem && ack == 0) begin
      mErr = 2'b10; mHalted = 1'b1;
    end else begin
      mRetired = mRetired + 32'd1;
    end
  endtask

  logic [5:0] legalOps [10] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h0d, 6'h09, 6'h23, 6'h2b, 6'h04, 6'h02};
  logic [5:0] rFuncs   [4]  = '{6'h21, 6'h23, 6'h25, 6'h2a};

  initial begin
    bit legal; int kind; logic [2:0] aluc;
    logic [5:0] o, f;
    int k, r, ack, abortAt;

    $display("[TB] mc_ctrl scoreboard bench starting");
    doReset(2);
    runInstr(6'h00, 6'h21, 1'b0, 1, -1, "addu");
    runInstr(6'h23, 6'h15, 1'b0, 3, -1, "lw-ack3");
    runInstr(6'h04, 6'h00, 1'b1, 1, -1, "beq-z1");
    runInstr(6'h04, 6'h00, 1'b0, 1, -1, "beq-z0");
    runInstr(6'h02, 6'h3f, 1'b0, 1, -1, "j");
    runInstr(6'h3f, 6'h00, 1'b0, 1, -1, "illegal");
    runHalt(20);
    doReset(1);
    runInstr(6'h2b, 6'h00, 1'b0, 0, -1, "sw-timeout");
    runHalt(3);
    doReset(1);
    runInstr(6'h2b, 6'h00, 1'b0, 15, -1, "sw-ack15");
    runInstr(6'h00, 6'h2a, 1'b0, 1, -1, "slt");
    runInstr(6'h23, 6'h00, 1'b0, 5, 4, "lw-rst");
    runInstr(6'h0d, 6'h00, 1'b0, 1, -1, "ori-after-rst");

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        do begin
          o = ($urandom_range(0, 1) == 1) ? 6'h00 : 6'($urandom_range(0, 63));
          f = 6'($urandom_range(0, 63));
          lookupInstr(o, f, legal, kind, aluc);
        end while (legal);
      end else begin
        k = $urandom_range(0, 9);
        o = legalOps[k];
        f = (k < 4) ? rFuncs[k] : 6'($urandom_range(0, 63));
      end
      r = $urandom_range(0, 99);
      if (r < 5)       ack = 0;
      else if (r < 9)  ack = 15;
      else             ack = $urandom_range(1, 5);
      abortAt = ($urandom_range(0, 99) < 4) ? $urandom_range(0, 7) : -1;
      runInstr(o, f, 1'($urandom_range(0, 1)), ack, abortAt, "rand");
      if (mHalted) begin
        runHalt($urandom_range(1, 4));
        doReset($urandom_range(1, 2));
      end
    end

    repeat (3) @(negedge clk);
    nCompared++;
    if (expQ.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller for the MIPS-subset datapath (addu, subu, or, slt, ori, addiu, lw, sw, beq, j). It replaces single-cycle decode by stepping each instruction through IF/ID/EX/MEM/WB states over the shared ALU/PC/IR/register-file datapath, and it handshakes with a variable-latency data memory. It also keeps a retired-instruction count and a halt/error status for the debug port.

## Interface
- MEM_TIMEOUT, 15: maximum MEM-state wait cycles before a bus error (4-bit counter; legal range 1..15).
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- op  in  6  IR[31:26]; stable from the end of IF until the next IF
- func  in  6  IR[5:0]
- Zero  in  1  ALU zero flag, valid in EX
- mem_ack  in  1  data memory done; sampled in MEM only
- PCWr  out  1  PC load enable
- PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = jump target
- IRWr  out  1  IR load enable
- ExtOp  out  1  1 = sign-extend imm16, 0 = zero-extend
- ALUSrc  out  1  1 = immediate operand B
- ALUctr  out  3  000 add, 100 sub, 010 or, 111 slt
- RegDst  out  1  1 = rd, 0 = rt
- RegWr  out  1  register file write enable
- MemtoReg  out  1  1 = write-back from MDR
- MemRead  out  1  data memory read request
- MemWr  out  1  data memory write request
- state  out  3  current state (debug)
- halted  out  1  sticky halt
- err  out  2  00 none, 01 illegal instruction, 10 bus timeout
- retired  out  32  count of completed instructions

## Operation
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=7. Codes 5 and 6 go to IF.
- IF: IRWr=1, PCWr=1, PCSrc=00. Next state is ID.
- ID: decode is registered at the end of this state as a class (R, ORI, ADDIU, LW, SW, BEQ, J) plus ALUctr.
  - R-type func: 100001 -> 000, 100011 -> 100, 100101 -> 010, 101010 -> 111.
  - ORI -> 010. ADDIU/LW/SW -> 000. BEQ -> 100.
  - Unknown op, or unknown func with op=000000: err=01, next state HALT.
  - J: PCWr=1, PCSrc=10, retired+1, next state IF.
  - All other legal instructions go to EX.
- EX: ALUctr from the latch. ALUSrc=1 for ORI/ADDIU/LW/SW. ExtOp=1 for ADDIU/LW/SW.
  - BEQ: PCWr=Zero, PCSrc=01, retired+1, next state IF.
  - R/ORI/ADDIU go to WB. LW/SW go to MEM.
- MEM: MemRead (LW) or MemWr (SW) is held high every cycle until mem_ack=1. wait_cnt is cleared on entry and incremented each cycle without ack.
  - Ack on LW: next state WB.
  - Ack on SW: retired+1, next state IF.
  - If wait_cnt reaches MEM_TIMEOUT with no ack: err=10, next state HALT, and the request drops on the next cycle.
  - Ack in the same cycle the timeout is reached: ack wins.
- WB: RegWr=1. RegDst=1 for R. MemtoReg=1 for LW. retired+1, next state IF.
- HALT: all enables are 0 and halted=1. Only rst leaves this state.
- Any output not listed for a state is 0.

## Timing
- Reset (rst high at a clock edge): state=IF, halted=0, err=00, retired=0, wait_cnt=0, decode latch cleared to class R / ALUctr 000.
- While rst is high, every output enable (PCWr, IRWr, RegWr, MemRead, MemWr) is forced to 0 combinationally.
- Reset wins over every other event, including mid-MEM. The memory request drops in the same cycle rst is high.
- Outputs are Moore (state plus latched decode), with one exception: PCWr in EX for BEQ follows Zero combinationally.
- Cycles per instruction: J 2, BEQ 3, R/ORI/ADDIU 4, SW 3+w, LW 4+w, where w is the number of MEM cycles before ack (w ≥ 1).
- retired increments on the clock edge that ends the instruction's final state, and wraps at 2^32-1 to 0.
- The first IF follows the first clock edge after rst deasserts.

## Test plan
- Reset, then addu (op=000000, func=100001): states IF, ID, EX, WB, IF. In EX, ALUctr=000 and ALUSrc=0. In WB, RegWr=1 and RegDst=1. retired=1 after 4 cycles.
- lw (op=100011) with mem_ack asserted on the 3rd MEM cycle: MemRead=1 for exactly 3 cycles, then WB with MemtoReg=1 and RegWr=1. 7 cycles total.
- beq (op=000100) run twice:
  - Zero=1: PCWr=1 and PCSrc=01 in EX.
  - Zero=0: PCWr=0.
  - Both: retired +1, and the next state is IF.
- j (op=000010): PCWr=1, PCSrc=10 in ID, instruction completes in 2 cycles. Then op=111111: HALT, err=01, halted=1; it stays there 20 cycles until rst.
- sw with mem_ack held 0: MemWr high for 15 cycles, then HALT with err=10. Separately, ack on exactly cycle 15: normal completion with err=00.
- rst pulsed during the 2nd MEM cycle of lw: MemRead=0 in that cycle, then state=IF, retired=0, err=00.
